mult_seq_ctrl: RTL and testbench
================================

Name: mult_seq_ctrl

Overview:
- Sequential shift-add multiplier control unit with its own datapath.
- Sits on the initiator side of the bit-counter interface. It drives the counter's load (CNT_RESET) and decrement (CNT_DECREMENT) strobes and reads back the 3-bit count to know when all multiplier bits are consumed.
- Accepts operands through a start/ready handshake and returns a registered product with a one-cycle done pulse.

Parameters:
- WIDTH, 4, operand width in bits. It must equal the value the paired counter loads on CNT_RESET (4).
- CNT_W, 3, width of the count input.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a multiplication; sampled only while ready=1.
- a  input  WIDTH  multiplicand, captured when start is accepted.
- b  input  WIDTH  multiplier, captured when start is accepted.
- ready  output  1  high in IDLE only.
- done  output  1  one-cycle pulse; product is valid from this cycle.
- product  output  2*WIDTH  registered result; held until the next accepted start.
- CNT_RESET  output  1  load strobe to the counter.
- CNT_DECREMENT  output  1  decrement strobe to the counter.
- count  input  CNT_W  current counter value.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high, named reset; clock named clk.
- Reset values:
  - state=IDLE, ready=1, done=0.
  - product=0, CNT_RESET=0, CNT_DECREMENT=0.
  - Internal M, ACC, Q and carry C all 0.
- Reset mid-operation: any in-flight result is discarded. Next cycle is IDLE; CNT strobes go low on the same edge.
- States: IDLE, LOAD, TEST, ADD, SHIFT, DONE.
- IDLE:
  - ready=1.
  - On start=1: M<=a, Q<=b, ACC<=0, C<=0, go to LOAD.
  - product is not cleared.
- LOAD: CNT_RESET=1 for exactly one cycle, then go to TEST.
- TEST:
  - If count==0, go to DONE.
  - Else if Q[0]=1, go to ADD.
  - Else go to SHIFT.
- ADD: {C,ACC} <= ACC + M, computed at WIDTH+1 bits; go to SHIFT.
- SHIFT:
  - {C,ACC,Q} <= {1'b0,C,ACC,Q} >> 1 (logical).
  - CNT_DECREMENT=1 for this cycle only; go to TEST.
- DONE:
  - product <= {ACC,Q}, done=1 for one cycle, go to IDLE.
- Counter strobes:
  - CNT_RESET and CNT_DECREMENT are never high in the same cycle.
  - Both are combinational from state, glitch-free (registered state).
- Latency: with start sampled in cycle 0, LOAD is cycle 1 and done is high in cycle 11+popcount(b) for WIDTH=4.
  - Minimum 11 cycles (b=0); maximum 15 cycles (b=4'hF).
- Busy behaviour: start while not IDLE is ignored, with no queueing. a and b are don't-care outside acceptance.
- Arithmetic:
  - Unsigned only.
  - Product fits exactly in 2*WIDTH bits, so no overflow is possible.
  - Carry from ADD enters ACC MSB on the following SHIFT.
- count treated as untrusted:
  - Any nonzero value continues iteration.
  - count==0 in TEST always terminates. If the counter is already 0 on the first TEST, DONE follows immediately with product={0,b}.

Optional Feature:
- Macro: MULT_TIMEOUT_EN.
- With the macro defined:
  - Adds output err (1 bit, reset 0) and an internal watchdog counter.
  - The watchdog counts cycles spent outside IDLE.
  - If it reaches 4*WIDTH+4 (20) without entering DONE: go to IDLE, err=1, done stays 0, product unchanged.
  - err clears on the next accepted start or on reset.
- Without the macro: no err port and no watchdog; a stuck count hangs the FSM until reset.

Test Plan:
- Reset then idle → ready=1, done=0, product=0, CNT_RESET=CNT_DECREMENT=0.
- a=5, b=3 with a behavioural counter model → product=15; done in cycle 13; exactly one CNT_RESET and four CNT_DECREMENT pulses.
- a=15, b=15 → product=225, done in cycle 15; a=9, b=0 → product=0, done in cycle 11.
- start=1 held through a busy run with a=2, b=2, then changed to a=7, b=7 mid-run → first product=4 only, no second run until ready.
- reset asserted in SHIFT during a=6, b=5 → next cycle IDLE, product=0, no done; a fresh a=6, b=5 run → product=30.
- MULT_TIMEOUT_EN with count stuck at 4 → err=1 after 20 busy cycles, FSM returns to IDLE, done never pulses.

Source files
------------

// File: rtl/mult_seq_ctrl.sv
// Shift-add multiplier driving an external bit counter; done pulses 11+popcount(b) cycles after start.
// Backpressure: start is only taken while ready (IDLE); define MULT_TIMEOUT_EN for the err watchdog.
module mult_seq_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               ready,
    output logic               done,
    output logic [2*WIDTH-1:0] product,
    output logic               CNT_RESET,
    output logic               CNT_DECREMENT,
    input  logic [CNT_W-1:0]   count
`ifdef MULT_TIMEOUT_EN
    ,
    output logic               err
`endif
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_TEST  = 3'd2;
    localparam logic [2:0] S_ADD   = 3'd3;
    localparam logic [2:0] S_SHIFT = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]         state_q, state_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic               c_q, c_d;
    logic [2*WIDTH-1:0] product_q, product_d;

`ifdef MULT_TIMEOUT_EN
    localparam int WD_LIMIT = 4 * WIDTH + 4;
    localparam int WD_W     = $clog2(WD_LIMIT + 1);
    logic [WD_W-1:0] wdog_q, wdog_d;
    logic            err_q, err_d;
`endif

    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        acc_d     = acc_q;
        q_d       = q_q;
        c_d       = c_q;
        product_d = product_q;
`ifdef MULT_TIMEOUT_EN
        err_d     = err_q;
        wdog_d    = (state_q == S_IDLE) ? '0 : wdog_q + 1'b1;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    m_d     = a;
                    q_d     = b;
                    acc_d   = '0;
                    c_d     = 1'b0;
                    state_d = S_LOAD;
`ifdef MULT_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                end
            end
            S_LOAD: state_d = S_TEST;
            S_TEST: begin
                // Capturing here makes product valid in the same cycle done is high.
                if (count == '0) begin
                    product_d = {acc_q, q_q};
                    state_d   = S_DONE;
                end else if (q_q[0]) begin
                    state_d = S_ADD;
                end else begin
                    state_d = S_SHIFT;
                end
            end
            S_ADD: begin
                {c_d, acc_d} = {1'b0, acc_q} + {1'b0, m_q};
                state_d      = S_SHIFT;
            end
            S_SHIFT: begin
                q_d     = {acc_q[0], q_q[WIDTH-1:1]};
                acc_d   = {c_q, acc_q[WIDTH-1:1]};
                c_d     = 1'b0;
                state_d = S_TEST;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
`ifdef MULT_TIMEOUT_EN
        // Abort overrides whatever the FSM chose, including a late capture.
        if (state_q != S_IDLE && state_q != S_DONE && wdog_q == WD_W'(WD_LIMIT - 1)) begin
            state_d   = S_IDLE;
            product_d = product_q;
            err_d     = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            m_q       <= '0;
            acc_q     <= '0;
            q_q       <= '0;
            c_q       <= 1'b0;
            product_q <= '0;
`ifdef MULT_TIMEOUT_EN
            wdog_q    <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            acc_q     <= acc_d;
            q_q       <= q_d;
            c_q       <= c_d;
            product_q <= product_d;
`ifdef MULT_TIMEOUT_EN
            wdog_q    <= wdog_d;
            err_q     <= err_d;
`endif
        end
    end

    assign ready         = (state_q == S_IDLE);
    assign done          = (state_q == S_DONE);
    assign CNT_RESET     = (state_q == S_LOAD);
    assign CNT_DECREMENT = (state_q == S_SHIFT);
    assign product       = product_q;
`ifdef MULT_TIMEOUT_EN
    assign err           = err_q;
`endif

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Bench for mult_seq_ctrl: timeline reference model with a behavioural bit counter and literal spot checks.
module tb_mult_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] a, b;
    logic       ready, done, CNT_RESET, CNT_DECREMENT;
    logic [7:0] product;
    logic [2:0] count;
`ifdef MULT_TIMEOUT_EN
    logic       err;
`endif

    int errors = 0;
    int checks = 0;
    bit chk_en = 0;
    bit stuck  = 0;

    always #5 clk = ~clk;

    mult_seq_ctrl #(.WIDTH(4), .CNT_W(3)) dut (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
        .ready(ready), .done(done), .product(product),
        .CNT_RESET(CNT_RESET), .CNT_DECREMENT(CNT_DECREMENT), .count(count)
`ifdef MULT_TIMEOUT_EN
        , .err(err)
`endif
    );

    // Behavioural bit counter: loads 4, decrements toward 0; can be forced stuck at 4.
    logic [2:0] cnt;
    always @(posedge clk) begin
        if (reset)                           cnt <= 3'd0;
        else if (CNT_RESET)                  cnt <= 3'd4;
        else if (CNT_DECREMENT && cnt != 0)  cnt <= cnt - 3'd1;
    end
    assign count = stuck ? 3'd4 : cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Timeline model: cycle index since acceptance; done at 11+popcount(b).
    bit       m_busy = 0;
    int       m_cyc  = 0;
    int       m_lat  = 0;
    bit [7:0] m_pend = 0;
    bit [7:0] m_prod = 0;
    bit       m_err  = 0;

    always @(posedge clk) begin
        if (reset) begin
            m_busy <= 0;
            m_prod <= 0;
            m_err  <= 0;
        end else if (!m_busy) begin
            if (start) begin
                m_busy <= 1;
                m_cyc  <= 1;
                m_lat  <= stuck ? 9999 : 11 + $countones(b);
                m_pend <= {4'b0, a} * {4'b0, b};
                m_err  <= 0;
            end
        end else if (m_cyc == m_lat) begin
            m_busy <= 0;
`ifdef MULT_TIMEOUT_EN
        end else if (m_cyc == 20) begin
            m_busy <= 0;
            m_err  <= 1;
`endif
        end else begin
            m_cyc <= m_cyc + 1;
            if (m_cyc + 1 == m_lat) m_prod <= m_pend;
        end
    end

    int dec_seen = 0;
    always @(negedge clk) begin
        if (chk_en) begin
            chk("ready", ready, !m_busy);
            chk("done", done, m_busy && m_cyc == m_lat);
            chk("cnt_reset", CNT_RESET, m_busy && m_cyc == 1);
            chk("product", product, m_prod);
            chk("strobe_overlap", CNT_RESET && CNT_DECREMENT, 0);
`ifdef MULT_TIMEOUT_EN
            chk("err", err, m_err);
`endif
            if (done && !stuck) chk("dec_per_run", dec_seen, 4);
            if (CNT_RESET) dec_seen <= 0;
            else if (CNT_DECREMENT) dec_seen <= dec_seen + 1;
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!ready && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        if (!ready) chk("wait_ready_timeout", 0, 1);
    endtask

    task automatic run_lit(input logic [3:0] ta, input logic [3:0] tb, input int ep, input int ec);
        int n = 0;
        int rs = 0;
        int dc = 0;
        bit got = 0;
        wait_ready();
        a = ta; b = tb; start = 1;
        @(posedge clk); #1 start = 0;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            if (CNT_RESET) rs++;
            if (CNT_DECREMENT) dc++;
            if (done) got = 1;
        end
        chk("lit_latency", n, ec);
        chk("lit_product", product, ep);
        chk("lit_cnt_reset_pulses", rs, 1);
        chk("lit_cnt_dec_pulses", dc, 4);
        @(posedge clk); #1;
    endtask

    initial begin
        int n;
        reset = 1; start = 0; a = 0; b = 0;
        repeat (3) @(posedge clk);
        #1 reset = 0;
        chk_en = 1;
        @(negedge clk);
        chk("rst_ready", ready, 1);
        chk("rst_done", done, 0);
        chk("rst_product", product, 0);
        chk("rst_cnt_reset", CNT_RESET, 0);
        chk("rst_cnt_dec", CNT_DECREMENT, 0);
`ifdef MULT_TIMEOUT_EN
        chk("rst_err", err, 0);
`endif
        @(posedge clk); #1;

        run_lit(4'd5, 4'd3, 15, 13);
        run_lit(4'd15, 4'd15, 225, 15);
        run_lit(4'd9, 4'd0, 0, 11);

        // start held through a busy run, operands changed mid-run
        wait_ready();
        a = 4'd2; b = 4'd2; start = 1;
        @(posedge clk);
        repeat (3) @(posedge clk);
        #1 a = 4'd7; b = 4'd7;
        n = 0;
        do begin @(negedge clk); n++; end while (!done && n < 40);
        chk("held_start_product", product, 4);
        start = 0;
        @(posedge clk); @(negedge clk);
        chk("held_start_no_rerun", ready, 1);
        repeat (3) @(posedge clk); #1;

        // reset while in SHIFT
        wait_ready();
        a = 4'd6; b = 4'd5; start = 1;
        @(posedge clk); #1 start = 0;
        n = 0;
        do begin @(negedge clk); n++; end while (!CNT_DECREMENT && n < 40);
        reset = 1;
        @(posedge clk); #1 reset = 0;
        @(negedge clk);
        chk("midrst_ready", ready, 1);
        chk("midrst_product", product, 0);
        chk("midrst_done", done, 0);
        @(posedge clk); #1;
        run_lit(4'd6, 4'd5, 30, 13);

        // randomized traffic with occasional reset
        for (int i = 0; i < 500; i++) begin
            start = ($urandom_range(0, 2) == 0);
            a = 4'($urandom);
            b = 4'($urandom);
            reset = ($urandom_range(0, 149) == 0);
            @(posedge clk); #1;
        end
        reset = 0; start = 0;
        wait_ready();

        // counter stuck at a nonzero value
        stuck = 1;
        a = 4'd3; b = 4'd5; start = 1;
        @(posedge clk); #1 start = 0;
        repeat (30) @(posedge clk);
        @(negedge clk);
`ifdef MULT_TIMEOUT_EN
        chk("stuck_err", err, 1);
        chk("stuck_ready", ready, 1);
        stuck = 0;
        @(posedge clk); #1;
        run_lit(4'd3, 4'd5, 15, 13);
        @(negedge clk);
        chk("err_cleared", err, 0);
`else
        chk("stuck_hang", ready, 0);
        stuck = 0;
        reset = 1;
        @(posedge clk); #1 reset = 0;
        @(negedge clk);
        chk("stuck_reset_ready", ready, 1);
`endif
        @(posedge clk); #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

endmodule
